// File: rtl/score_bcd_encoder.sv
// Sequential binary-to-BCD encoder (shift-and-add-3) for the score display path.
// The result registers only change on the done edge, so the display never sees partial values.
module score_bcd_encoder #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int WW = 4 * (DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [WW-1:0]         work_q, work_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  lost_q, lost_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic [WW-1:0]         adj;
  logic [WW+WIDTH-1:0]   shifted;

  function automatic logic [WW-1:0] add3_digits(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    r = w;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (w[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = w[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = w[4*i +: 4];
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      lost_q  <= lost_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
        else       state_d = IDLE;
      end
      SHIFT: begin
        if (cnt_q == CW'(1)) state_d = DONE;
        else                 state_d = SHIFT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bin_d   = bin_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    lost_d  = lost_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    adj     = add3_digits(work_q);
    shifted = {adj, bin_q} << 1;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d  = bin;
          work_d = '0;
          cnt_d  = CW'(WIDTH);
          lost_d = 1'b0;
        end else begin
          bin_d  = bin_q;
        end
      end
      SHIFT: begin
        {work_d, bin_d} = shifted;
        cnt_d  = cnt_q - CW'(1);
        // A bit pushed out of the extra digit also means the value exceeded the display range.
        lost_d = lost_q | adj[WW-1];
        if (cnt_q == CW'(1)) begin
          ovf_d  = lost_d || (work_d[WW-1 -: 4] != 4'd0);
          bcd_d  = ovf_d ? {DIGITS{4'h9}} : work_d[4*DIGITS-1:0];
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      DONE:    done_d = 1'b0;
      default: done_d = 1'b0;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Bench for score_bcd_encoder: cycle model built from decimal arithmetic plus hand-computed literals,
// with a second 2-digit/8-bit instance for the overflow saturation cases.
module tb_score_bcd_encoder;

  logic        clk = 1'b0;
  logic        clr, start, start2;
  logic [9:0]  bin;
  logic [7:0]  bin2;
  logic        busy, done, ovf, busy2, done2, ovf2;
  logic [15:0] bcd;
  logic [7:0]  bcd2;

  always #5 clk = ~clk;

  score_bcd_encoder #(.WIDTH(10), .DIGITS(4)) dut (
    .clk(clk), .clr(clr), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(ovf));

  score_bcd_encoder #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .clr(clr), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2));

  int n_checks = 0;
  int n_fail   = 0;

  // hand-computed results, in the order the done pulses must appear
  logic [15:0] lit1_bcd [6];
  logic        lit1_ovf [6];
  logic [7:0]  lit2_bcd [2];
  logic        lit2_ovf [2];
  int          li1 = 0, li2 = 0;
  logic        end_req = 1'b0, end_ack = 1'b0;

  // model state
  logic        m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0, m_rst = 1'b0;
  logic [15:0] m_bcd = 16'h0000;
  int          m_left = 0, m_val = 0;
  logic        prev_done = 1'b0;

  function automatic logic [16:0] enc(input int v, input int digits);
    int          lim;
    int          x;
    logic [15:0] r;
    lim = 1;
    x   = v;
    r   = 16'h0000;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    if (v >= lim) begin
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
      return {1'b1, r};
    end
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, r};
  endfunction

  // timing model: accept in idle, done on the WIDTH-th edge after accept, idle one edge later
  always @(posedge clk) begin
    m_rst = !clr;
    if (!clr) begin
      m_busy = 1'b0; m_done = 1'b0; m_bcd = 16'h0000; m_ovf = 1'b0; m_left = 0;
    end else if (m_left == 0) begin
      m_done = 1'b0;
      if (start) begin
        m_val = int'(bin); m_left = 11; m_busy = 1'b1;
      end
    end else begin
      m_left = m_left - 1;
      m_done = 1'b0;
      if (m_left == 1) begin
        {m_ovf, m_bcd} = enc(m_val, 4);
        m_done = 1'b1;
      end else if (m_left == 0) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", {15'd0, busy}, {15'd0, m_busy});
    chk("done", {15'd0, done}, {15'd0, m_done});
    chk("bcd", bcd, m_bcd);
    chk("overflow", {15'd0, ovf}, {15'd0, m_ovf});
    chk("done_single_pulse", {15'd0, prev_done & done}, 16'd0);
    prev_done = done;
    if (m_rst) begin
      chk("reset_bcd", bcd, 16'h0000);
      chk("reset_busy", {15'd0, busy}, 16'd0);
    end
    if (done && li1 < 6) begin
      chk("lit_bcd", bcd, lit1_bcd[li1]);
      chk("lit_ovf", {15'd0, ovf}, {15'd0, lit1_ovf[li1]});
      li1++;
    end
    if (done2 && li2 < 2) begin
      chk("lit2_bcd", {8'd0, bcd2}, {8'd0, lit2_bcd[li2]});
      chk("lit2_ovf", {15'd0, ovf2}, {15'd0, lit2_ovf[li2]});
      li2++;
    end
    if (end_req && !end_ack) begin
      chk("done_count", 16'(li1), 16'd6);
      chk("done2_count", 16'(li2), 16'd2);
      end_ack = 1'b1;
    end
  end

  task automatic go(input logic [9:0] v);
    @(negedge clk); bin = v; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic go2(input logic [7:0] v);
    @(negedge clk); bin2 = v; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    lit1_bcd[0] = 16'h0000; lit1_bcd[1] = 16'h1023; lit1_bcd[2] = 16'h0999;
    lit1_bcd[3] = 16'h0010; lit1_bcd[4] = 16'h0742; lit1_bcd[5] = 16'h0005;
    for (int i = 0; i < 6; i++) lit1_ovf[i] = 1'b0;
    lit2_bcd[0] = 8'h99; lit2_ovf[0] = 1'b1;
    lit2_bcd[1] = 8'h99; lit2_ovf[1] = 1'b0;

    clr = 1'b0; start = 1'b0; start2 = 1'b0; bin = 10'd0; bin2 = 8'd0;
    repeat (2) @(negedge clk);
    clr = 1'b1;

    go(10'd0);
    go(10'd1023);
    go(10'd999);
    go(10'd10);

    // start held high; bin changes mid-conversion
    @(negedge clk); bin = 10'd742; start = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    bin = 10'd5;
    repeat (9) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // reset in the middle of a conversion
    @(negedge clk); bin = 10'd512; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    repeat (14) @(negedge clk);

    go2(8'd150);
    go2(8'd99);

    end_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
